picosoc_dma: RTL
================

PICOSOC_DMA -- requirements
Module: picosoc_dma

Interface
REQ-001 SHALL have parameter LEN_BITS, default 16: width of the word-count register LEN.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have config-responder inputs: cfg_valid (1), cfg_addr (4; bits [3:2] select the register), cfg_wstrb (4), cfg_wdata (32).
REQ-005 SHALL have config-responder outputs: cfg_ready (1) and cfg_rdata (32).
REQ-006 SHALL have memory-initiator outputs: mem_valid (1), mem_addr (32), mem_wdata (32), mem_wstrb (4).
REQ-007 SHALL have memory-initiator inputs: mem_ready (1) and mem_rdata (32).
REQ-008 SHALL have output irq, 1 bit: transfer-complete interrupt.

Function
REQ-009 SHALL provide four registers: 0x0 SRC, 0x4 DST, 0x8 LEN (LEN_BITS, zero-extended on read), 0xC CTRL.
REQ-010 CTRL bits SHALL be: [0] start (write 1, reads 0), [1] busy (read-only), [2] done (write 1 to clear), [3] irq_en (R/W), [4] abort (write 1, reads 0), [5] aborted (write 1 to clear).
REQ-011 cfg_ready SHALL pulse high for exactly one cycle, the cycle after cfg_valid is sampled high with cfg_ready low.
REQ-012 cfg_rdata SHALL be valid while cfg_ready is high; writes honour each cfg_wstrb byte lane.
REQ-013 SRC and DST writes SHALL force bits [1:0] to 0.
REQ-014 While busy, writes to SRC, DST and LEN SHALL be ignored; reads return the live pointers and the remaining count.
REQ-015 States SHALL be IDLE, RD and WR.
REQ-016 IDLE->RD SHALL occur on a start write with LEN!=0; start with LEN==0 sets done without any bus cycle.
REQ-017 RD SHALL drive mem_valid=1, mem_wstrb=0, mem_addr=SRC.
REQ-018 On the edge where mem_valid&&mem_ready in RD, the block SHALL capture mem_rdata into a data buffer and go to WR.
REQ-019 WR SHALL drive mem_valid=1, mem_wstrb=4'hF, mem_addr=DST, mem_wdata=buffer.
REQ-020 On the edge where mem_valid&&mem_ready in WR: SRC+=4, DST+=4, LEN-=1; next state SHALL be RD if LEN>1, else IDLE with done=1.
REQ-021 mem_valid, mem_addr, mem_wdata and mem_wstrb SHALL be held stable until mem_ready; mem_valid SHALL NOT drop before mem_ready.
REQ-022 mem_valid SHALL be low for exactly one cycle after each accepted transaction before the next is issued.
REQ-023 Pointers SHALL wrap modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
REQ-024 Start while busy SHALL be ignored.
REQ-025 Abort while busy SHALL complete the outstanding bus transaction, then go to IDLE with aborted=1 and done unchanged; abort in IDLE is ignored.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 If a done write-1-clear coincides with completion, completion SHALL win (done=1).

Reset
REQ-028 On reset, SRC, DST, LEN and CTRL SHALL be 0; state SHALL be IDLE; mem_valid, mem_wstrb, cfg_ready and irq SHALL be 0.
REQ-029 Reset mid-transfer SHALL drop mem_valid on the next edge and discard the transfer.

Configuration
REQ-030 Macro PICOSOC_DMA_IRQ_EN defined: irq SHALL be registered and equal done & irq_en.
REQ-031 Macro PICOSOC_DMA_IRQ_EN undefined: irq SHALL be constant 0, and CTRL[3] SHALL read 0 and ignore writes.

Verification
REQ-032 SRC=0x100, DST=0x200, LEN=3, start; memory at 0x100..0x108 = A,B,C with zero-wait ready -> 0x200..0x208 = A,B,C; six transactions; done=1; LEN=0; SRC=0x10C.
REQ-033 LEN=2 with mem_ready delayed 3 cycles per transaction -> mem_addr and mem_wdata stable during every wait; final DST=base+8.
REQ-034 LEN=0, start -> no mem_valid ever asserted; done=1 on the cycle after the cfg write.
REQ-035 LEN=10, abort written during the 2nd WR -> that write completes; state IDLE; aborted=1; done=0; LEN=8.
REQ-036 SRC=0xFFFF_FFFC, LEN=2 -> second read address is 0x0000_0000.
REQ-037 With PICOSOC_DMA_IRQ_EN and irq_en=1, completion -> irq=1; write CTRL=0x4 -> irq=0 the following cycle; reset asserted mid-transfer -> mem_valid=0 on the next edge.

Source files
------------

// File: rtl/picosoc_dma.sv
// picosoc_dma: single-channel word-copy DMA engine.
//   A small config responder exposes SRC, DST, LEN and CTRL. A start copies
//   LEN words from SRC to DST. Each word is one read followed by one write on
//   a valid/ready memory initiator port.
//
// Ports
//   clk, reset                  single clock; synchronous active-high reset
//   cfg_valid/addr/wstrb/wdata  config request (cfg_addr[3:2] picks the register)
//   cfg_ready, cfg_rdata        one-cycle acknowledge with read data
//   mem_valid/addr/wdata/wstrb  memory request (wstrb==0 means read)
//   mem_ready, mem_rdata        memory acknowledge with read data
//   irq                         transfer-complete interrupt
//
// Build option
//   PICOSOC_DMA_IRQ_EN  when defined, irq is a registered done & irq_en and
//                       CTRL[3] is writable. When undefined, irq is tied low
//                       and CTRL[3] reads 0.
//
// CTRL: [0] start  [1] busy  [2] done (W1C)  [3] irq_en  [4] abort  [5] aborted (W1C)
module picosoc_dma #(
  parameter int LEN_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  input  logic [3:0]  cfg_addr,
  input  logic [3:0]  cfg_wstrb,
  input  logic [31:0] cfg_wdata,
  output logic        cfg_ready,
  output logic [31:0] cfg_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  logic [1:0]          r_state;
  logic [31:0]         r_src;
  logic [31:0]         r_dst;
  logic [LEN_BITS-1:0] r_len;
  logic [31:0]         r_buf;
  logic                r_done;
  logic                r_aborted;
  logic                r_abort_pend;
  logic                r_mem_valid;
  logic                r_cfg_ready;
  logic [31:0]         r_cfg_rdata;

  logic        w_cfg_acc;
  logic [1:0]  w_sel;
  logic        w_busy;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_abort;
  logic        w_stop;
  logic        w_irq_en_rd;
  logic [31:0] w_len_ext;
  logic [31:0] w_len_merged;
  logic [31:0] w_ctrl_rd;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // A request is taken on the edge where it is seen while the previous ack
  // is not showing; that edge also performs the register access.
  assign w_cfg_acc    = cfg_valid & ~r_cfg_ready;
  assign w_sel        = cfg_addr[3:2];
  assign w_busy       = (r_state != S_IDLE);
  assign w_ctrl_wr    = w_cfg_acc & (w_sel == 2'd3) & cfg_wstrb[0];
  assign w_start      = w_ctrl_wr & cfg_wdata[0];
  assign w_abort      = w_ctrl_wr & cfg_wdata[4];
  assign w_stop       = r_abort_pend | w_abort;
  assign w_len_ext    = 32'(r_len);
  assign w_len_merged = f_merge(w_len_ext, cfg_wdata, cfg_wstrb);
  assign w_ctrl_rd    = {26'd0, r_aborted, 1'b0, w_irq_en_rd, r_done, w_busy, 1'b0};
  assign w_unused     = ^cfg_addr[1:0];

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_sel)
      2'd0:    w_rd_mux = r_src;
      2'd1:    w_rd_mux = r_dst;
      2'd2:    w_rd_mux = w_len_ext;
      default: w_rd_mux = w_ctrl_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_src        <= 32'd0;
      r_dst        <= 32'd0;
      r_len        <= '0;
      r_buf        <= 32'd0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_cfg_ready  <= 1'b0;
      r_cfg_rdata  <= 32'd0;
    end else begin
      r_cfg_ready <= w_cfg_acc;
      if (w_cfg_acc) r_cfg_rdata <= w_rd_mux;

      // Pointer/count writes only land while idle; when busy the FSM owns them.
      if (w_cfg_acc && !w_busy) begin
        if (w_sel == 2'd0) r_src <= f_merge(r_src, cfg_wdata, cfg_wstrb) & 32'hFFFF_FFFC;
        if (w_sel == 2'd1) r_dst <= f_merge(r_dst, cfg_wdata, cfg_wstrb) & 32'hFFFF_FFFC;
        if (w_sel == 2'd2) r_len <= w_len_merged[LEN_BITS-1:0];
      end
      if (w_ctrl_wr) begin
        if (cfg_wdata[2]) r_done    <= 1'b0;
        if (cfg_wdata[5]) r_aborted <= 1'b0;
      end

      // Set paths come after the W1C clears so a coincident completion wins.
      case (r_state)
        S_IDLE: begin
          r_abort_pend <= 1'b0;
          if (w_start) begin
            if (r_len != '0) r_state <= S_RD;
            else             r_done  <= 1'b1;
          end
        end
        S_RD: begin
          if (w_abort) r_abort_pend <= 1'b1;
          if (!r_mem_valid) begin
            r_mem_valid <= 1'b1;
          end else if (mem_ready) begin
            r_buf       <= mem_rdata;
            r_mem_valid <= 1'b0;
            if (w_stop) begin
              r_state   <= S_IDLE;
              r_aborted <= 1'b1;
            end else begin
              r_state <= S_WR;
            end
          end
        end
        S_WR: begin
          if (w_abort) r_abort_pend <= 1'b1;
          if (!r_mem_valid) begin
            r_mem_valid <= 1'b1;
          end else if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_src       <= r_src + 32'd4;
            r_dst       <= r_dst + 32'd4;
            r_len       <= r_len - LEN_BITS'(1);
            if (r_len > LEN_BITS'(1)) begin
              if (w_stop) begin
                r_state   <= S_IDLE;
                r_aborted <= 1'b1;
              end else begin
                r_state <= S_RD;
              end
            end else begin
              // Last word: the copy is complete even if an abort is pending.
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PICOSOC_DMA_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= cfg_wdata[3];
      r_irq <= r_done & r_irq_en;
    end
  end

  assign w_irq_en_rd = r_irq_en;
  assign irq         = r_irq;
`else
  assign w_irq_en_rd = 1'b0;
  assign irq         = 1'b0;
`endif

  assign cfg_ready = r_cfg_ready;
  assign cfg_rdata = r_cfg_rdata;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = (r_state == S_WR) ? r_dst : r_src;
  assign mem_wdata = r_buf;
  assign mem_wstrb = (r_state == S_WR) ? 4'hF : 4'h0;

endmodule
